// File: rtl/pwm_ctrl_pkg.sv
// Shared types, default widths and duty-step arithmetic for the PWM ramp controller.
package pwm_ctrl_pkg;

  localparam int unsigned WORD_LENGTH = 8;
  localparam int unsigned FREQ_LENGTH = 2;
  localparam int unsigned DWELL_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RAMP = 2'd1,
    HOLD = 2'd2,
    STOP = 2'd3
  } state_t;

  // Move cur toward tgt by stp, clamping at tgt so the result never overshoots or wraps.
  function automatic logic [31:0] step_duty(input logic [31:0] cur,
                                            input logic [31:0] tgt,
                                            input logic [31:0] stp);
    logic [31:0] nxt;
    if (cur < tgt) begin
      nxt = ((tgt - cur) <= stp) ? tgt : cur + stp;
    end else begin
      nxt = ((cur - tgt) <= stp) ? tgt : cur - stp;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/pwm_dwell_timer.sv
// Loadable down-counter that ticks once every reload period while enabled.
module pwm_dwell_timer #(
  parameter int unsigned DWELL_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   load,
  input  logic [DWELL_WIDTH-1:0] load_val,
  input  logic                   enable,
  output logic                   tick
);

  logic [DWELL_WIDTH-1:0] count;
  logic [DWELL_WIDTH-1:0] reload;

  assign tick = enable && !load && (count == DWELL_WIDTH'(1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count  <= '0;
      reload <= '0;
    end else if (load) begin
      count  <= load_val;
      reload <= load_val;
    end else if (enable) begin
      count <= (count == DWELL_WIDTH'(1)) ? reload : count - DWELL_WIDTH'(1);
    end
  end

endmodule

// File: rtl/pwm_ramp_ctrl.sv
// Command-driven soft-start/soft-stop sequencer feeding the PWM start/duty/frequency inputs.
module pwm_ramp_ctrl #(
  parameter int unsigned WORD_LENGTH = pwm_ctrl_pkg::WORD_LENGTH,
  parameter int unsigned FREQ_LENGTH = pwm_ctrl_pkg::FREQ_LENGTH,
  parameter int unsigned DWELL_WIDTH = pwm_ctrl_pkg::DWELL_WIDTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [WORD_LENGTH-1:0] cmd_duty,
  input  logic [WORD_LENGTH-1:0] cmd_step,
  input  logic [FREQ_LENGTH-1:0] cmd_freq,
  input  logic [DWELL_WIDTH-1:0] cmd_dwell,
  input  logic                   stop_req,
  output logic                   start,
  output logic [WORD_LENGTH-1:0] dutyCycle,
  output logic [FREQ_LENGTH-1:0] frequency,
  output logic                   busy,
  output logic                   at_target
);

  import pwm_ctrl_pkg::*;

  state_t                 state;
  logic [WORD_LENGTH-1:0] target;
  logic [WORD_LENGTH-1:0] step;
  logic [DWELL_WIDTH-1:0] dwell;

  logic                   accept;
  logic                   stop_take;
  logic                   tick;
  logic                   tmr_load;
  logic                   tmr_enable;
  logic [DWELL_WIDTH-1:0] tmr_val;
  logic [DWELL_WIDTH-1:0] cmd_dwell_eff;
  logic [WORD_LENGTH-1:0] cmd_step_eff;
  logic [WORD_LENGTH-1:0] next_duty;

  // stop_req masks ready, so a simultaneous command is never accepted
  assign cmd_ready     = ((state == IDLE) || (state == HOLD)) && !stop_req;
  assign accept        = cmd_valid && cmd_ready;
  assign stop_take     = stop_req && ((state == RAMP) || (state == HOLD));
  assign cmd_step_eff  = (cmd_step == '0) ? WORD_LENGTH'(1) : cmd_step;
  assign cmd_dwell_eff = (cmd_dwell == '0) ? DWELL_WIDTH'(1) : cmd_dwell;

  assign tmr_load   = accept || stop_take;
  assign tmr_val    = accept ? cmd_dwell_eff : dwell;
  assign tmr_enable = (state == RAMP) || (state == STOP);
  assign next_duty  = WORD_LENGTH'(step_duty(32'(dutyCycle), 32'(target), 32'(step)));

  pwm_dwell_timer #(
    .DWELL_WIDTH (DWELL_WIDTH)
  ) u_dwell_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .enable   (tmr_enable),
    .tick     (tick)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      target    <= '0;
      step      <= '0;
      dwell     <= '0;
      start     <= 1'b0;
      dutyCycle <= '0;
      frequency <= '0;
      busy      <= 1'b0;
      at_target <= 1'b0;
    end else begin
      case (state)
        IDLE, HOLD: begin
          if (stop_take) begin
            state     <= STOP;
            target    <= '0;
            at_target <= 1'b0;
          end else if (accept) begin
            target    <= cmd_duty;
            step      <= cmd_step_eff;
            dwell     <= cmd_dwell_eff;
            frequency <= cmd_freq;
            start     <= 1'b1;
            busy      <= 1'b1;
            if (dutyCycle == cmd_duty) begin
              state     <= HOLD;
              at_target <= 1'b1;
            end else begin
              state     <= RAMP;
              at_target <= 1'b0;
            end
          end
        end
        RAMP: begin
          if (stop_take) begin
            state  <= STOP;
            target <= '0;
          end else if (tick) begin
            dutyCycle <= next_duty;
            if (next_duty == target) begin
              state     <= HOLD;
              at_target <= 1'b1;
            end
          end
        end
        STOP: begin
          // start drops one cycle after the duty has reached zero
          if (dutyCycle == '0) begin
            state <= IDLE;
            start <= 1'b0;
            busy  <= 1'b0;
          end else if (tick) begin
            dutyCycle <= next_duty;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/pwm_ramp_ctrl.md
Name: pwm_ramp_ctrl

Overview:
Command-driven sequencer that sits in front of the PWM generator and drives its start, dutyCycle and frequency inputs. It accepts ramp commands over a valid/ready handshake. It then steps dutyCycle from its current value toward a target by a fixed step once every programmable dwell interval, holds at the target, and performs a controlled ramp-down to zero on stop before deasserting start. This gives the PWM datapath soft-start/soft-stop without software polling.

Parameters:
WORD_LENGTH, 8, width of duty cycle and step values
FREQ_LENGTH, 2, width of PWM frequency select
DWELL_WIDTH, 16, width of dwell-interval counter (clock cycles per duty step)

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous, active-low reset
cmd_valid  input  1  command present
cmd_ready  output  1  controller can accept command
cmd_duty  input  WORD_LENGTH  target duty cycle
cmd_step  input  WORD_LENGTH  duty increment/decrement per dwell interval
cmd_freq  input  FREQ_LENGTH  PWM frequency select
cmd_dwell  input  DWELL_WIDTH  clock cycles between duty updates
stop_req  input  1  request ramp-down to 0 and stop
start  output  1  PWM enable, to PWM start
dutyCycle  output  WORD_LENGTH  PWM duty, to PWM dutyCycle
frequency  output  FREQ_LENGTH  PWM frequency select, to PWM frequency
busy  output  1  state is not IDLE
at_target  output  1  state is HOLD

Behaviour:
- One clock domain. reset is asynchronous and active-low (reset==0 clears all state). All outputs are registered except cmd_ready.
- Reset values: start=0, dutyCycle=0, frequency=0, busy=0, at_target=0, state=IDLE, dwell counter=0, latched target/step/dwell=0. cmd_ready=1 in IDLE after reset.
- States: IDLE, RAMP, HOLD, STOP.
- cmd_ready = (state==IDLE || state==HOLD) && !stop_req. This is combinational. Acceptance = cmd_valid && cmd_ready.
- On acceptance, in the next cycle:
  - target, step and dwell are latched. step==0 is treated as 1; dwell==0 is treated as 1.
  - frequency takes cmd_freq and start becomes 1.
  - The dwell counter is loaded with dwell.
  - Next state is RAMP, or HOLD if the current dutyCycle already equals cmd_duty.
- frequency changes only on acceptance, including in HOLD, where the change is immediate.
- RAMP:
  - The counter decrements each cycle. When the counter==1, dutyCycle updates and the counter reloads.
  - The first update occurs dwell cycles after the acceptance edge.
  - Direction is up if dutyCycle<target, else down.
  - Arithmetic is done at WORD_LENGTH+1 bits. The result saturates at target and never overshoots; an up-step cannot wrap past 2^WL-1 and a down-step cannot go below 0.
  - When the updated duty equals target: the same edge moves to HOLD and at_target=1 from the following cycle.
- HOLD: start=1 and duty is constant. A new command re-enters RAMP from the current duty (retarget, no reset to 0).
- stop_req, sampled in RAMP or HOLD:
  - Next state is STOP with target forced to 0. The latched step and dwell are kept and the counter is reloaded.
  - stop_req beats cmd_valid in the same cycle; the command is not accepted.
- STOP:
  - Ramps down as in RAMP with cmd_ready=0.
  - When duty reaches 0, the next cycle has start=0 and state IDLE. frequency retains its value.
  - If duty is already 0 on entry, start drops on the next cycle.
- stop_req in IDLE or STOP is ignored (no effect).
- Reset mid-operation: immediate return to reset values, start=0 asynchronously.

Decomposition:
- Package pwm_ctrl_pkg:
  - state enum (IDLE, RAMP, HOLD, STOP)
  - default width localparams WORD_LENGTH=8, FREQ_LENGTH=2, DWELL_WIDTH=16
  - saturating step function (current, target, step) -> next duty
- Sub-module pwm_dwell_timer:
  - Loadable down-counter.
  - Inputs: clk, reset, load, load_val, enable.
  - Output: tick, asserted when the count==1 and enabled, with auto-reload.

Test Plan:
1. Reset held low 50 ns, then release -> start=0, dutyCycle=0, busy=0, cmd_ready=1.
2. Command duty=8, step=2, dwell=3, freq=01 -> start=1, frequency=01, dutyCycle 0→2→4→6→8 at 3-cycle spacing, then at_target=1, cmd_ready=1.
3. From HOLD at 8, command duty=3, step=4, dwell=2 -> dutyCycle 8→4→3 (saturated, no undershoot to 0), then HOLD.
4. Command duty=250, step=10 from 245 -> dutyCycle 250, with no wrap beyond 255.
5. stop_req asserted in HOLD at 8 (step 2, dwell 3), with cmd_valid=1 the same cycle -> command rejected; dutyCycle 6,4,2,0, then start=0 one cycle later, state IDLE.
6. reset pulled low mid-RAMP at duty 4 -> start=0 and dutyCycle=0 immediately (asynchronously); after release, state IDLE and cmd_ready=1.
